// File: rtl/memory_access_if.sv
// EX/MA -> MA/WB bus for the memory-access stage; slave is the stage, master the driver.
// Debug read port fields exist only when MA_DEBUG_PORT_EN is defined.
interface memory_access_if #(
   parameter int NB_DATA           = 32,
   parameter int NB_CONTROL_MA     = 5,
   parameter int NB_CONTROL_WB     = 2,
   parameter int NB_ADDR_REGISTERS = 5,
   parameter int N_WORDS           = 256
);
   logic [NB_CONTROL_MA+NB_CONTROL_WB-1:0] i_control_ma_wb;
   logic [NB_DATA-1:0]                     i_result;
   logic [NB_DATA-1:0]                     i_w_data_mem;
   logic [NB_ADDR_REGISTERS-1:0]           i_rd_num;
   logic                                   i_stall;

   logic [NB_DATA-1:0]                     o_ex_rd_data;
   logic [NB_ADDR_REGISTERS-1:0]           o_ex_rd_num;
   logic                                   o_ex_ctl_wr;
   logic [NB_CONTROL_WB-1:0]               o_control_wb;
   logic [NB_DATA-1:0]                     o_mem_data;
   logic [NB_DATA-1:0]                     o_result;
   logic [NB_ADDR_REGISTERS-1:0]           o_rd_num;
   logic                                   o_align_err;

`ifdef MA_DEBUG_PORT_EN
   logic [$clog2(N_WORDS)-1:0]             i_dbg_addr;
   logic                                   i_dbg_rd;
   logic [NB_DATA-1:0]                     o_dbg_data;
`endif

   modport slave (
      input  i_control_ma_wb, i_result, i_w_data_mem, i_rd_num, i_stall,
      output o_ex_rd_data, o_ex_rd_num, o_ex_ctl_wr,
      output o_control_wb, o_mem_data, o_result, o_rd_num, o_align_err
`ifdef MA_DEBUG_PORT_EN
      , input i_dbg_addr, input i_dbg_rd, output o_dbg_data
`endif
   );

   modport master (
      output i_control_ma_wb, i_result, i_w_data_mem, i_rd_num, i_stall,
      input  o_ex_rd_data, o_ex_rd_num, o_ex_ctl_wr,
      input  o_control_wb, o_mem_data, o_result, o_rd_num, o_align_err
`ifdef MA_DEBUG_PORT_EN
      , output i_dbg_addr, output i_dbg_rd, input o_dbg_data
`endif
   );
endinterface

// File: rtl/memory_access.sv
// MIPS memory-access stage: byte/half/word load-store into private data memory, 1-cycle MA/WB register.
// Optional MA_DEBUG_PORT_EN adds a registered debug read port into the data memory.
module memory_access #(
   parameter int NB_DATA           = 32,
   parameter int NB_CONTROL_MA     = 5,
   parameter int NB_CONTROL_WB     = 2,
   parameter int NB_ADDR_REGISTERS = 5,
   parameter int N_WORDS           = 256
) (
   input logic            i_clk,
   input logic            i_reset,
   memory_access_if.slave bus
);
   localparam int NB_CTL = NB_CONTROL_MA + NB_CONTROL_WB;
   localparam int NB_IDX = $clog2(N_WORDS);

   logic [NB_CTL-1:0]  ctl;
   logic               mem_read;
   logic               mem_write;
   logic [1:0]         size;
   logic               is_unsigned;
   logic               reg_write;
   logic [1:0]         addr_lo;
   logic [NB_IDX-1:0]  widx;
   logic               unused_addr_hi;

   assign ctl         = bus.i_control_ma_wb;
   assign mem_read    = ctl[NB_CTL-1];
   assign mem_write   = ctl[NB_CTL-2];
   assign size        = ctl[NB_CTL-3 -: 2];
   assign is_unsigned = ctl[2];
   assign reg_write   = ctl[1];
   assign addr_lo     = bus.i_result[1:0];
   assign widx        = bus.i_result[NB_IDX+1:2];
   // Address bits above the memory span are don't-care: accesses wrap.
   assign unused_addr_hi = ^bus.i_result[NB_DATA-1:NB_IDX+2];

   // Contents are never reset; simulation starts them at zero.
   logic [NB_DATA-1:0] mem [N_WORDS];

   logic               misaligned;
   logic               align_bad;
   logic [NB_DATA-1:0] rd_word;
   logic [NB_DATA-1:0] shifted;
   logic [7:0]         lane_byte;
   logic [15:0]        lane_half;
   logic [NB_DATA-1:0] load_data;

   always_comb begin
      misaligned = 1'b0;
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_lo[0];
         default: misaligned = |addr_lo;
      endcase
   end

   assign align_bad = (mem_read | mem_write) & misaligned;

   assign rd_word   = mem[widx];
   assign shifted   = rd_word >> {addr_lo, 3'b000};
   assign lane_byte = shifted[7:0];
   assign lane_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = '0;
      if (mem_read && !misaligned) begin
         case (size)
            2'b00:   load_data = is_unsigned ? {24'd0, lane_byte}
                                             : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_data = is_unsigned ? {16'd0, lane_half}
                                             : {{16{lane_half[15]}}, lane_half};
            default: load_data = rd_word;
         endcase
      end
   end

   // Store path: replicate the store data across lanes, then merge under a byte mask.
   logic [3:0]         wr_mask;
   logic [NB_DATA-1:0] wr_lanes;
   logic [NB_DATA-1:0] bit_mask;
   logic [NB_DATA-1:0] wr_word;
   logic               wr_en;

   always_comb begin
      wr_mask  = 4'b0000;
      wr_lanes = '0;
      case (size)
         2'b00: begin
            wr_mask  = 4'b0001 << addr_lo;
            wr_lanes = {4{bus.i_w_data_mem[7:0]}};
         end
         2'b01: begin
            wr_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{bus.i_w_data_mem[15:0]}};
         end
         default: begin
            wr_mask  = 4'b1111;
            wr_lanes = bus.i_w_data_mem;
         end
      endcase
   end

   assign bit_mask = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};
   assign wr_word  = (rd_word & ~bit_mask) | (wr_lanes & bit_mask);
   assign wr_en    = mem_write & ~misaligned & ~bus.i_stall;

   // A reset held across the edge suppresses the write of that cycle.
   always_ff @(posedge i_clk) begin
      if (wr_en && !i_reset) begin
         mem[widx] <= wr_word;
      end
   end

   logic [NB_CONTROL_WB-1:0]     control_wb_q;
   logic [NB_DATA-1:0]           mem_data_q;
   logic [NB_DATA-1:0]           result_q;
   logic [NB_ADDR_REGISTERS-1:0] rd_num_q;
   logic                         align_err_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         control_wb_q <= '0;
         mem_data_q   <= '0;
         result_q     <= '0;
         rd_num_q     <= '0;
         align_err_q  <= 1'b0;
      end else if (!bus.i_stall) begin
         control_wb_q <= ctl[NB_CONTROL_WB-1:0];
         mem_data_q   <= load_data;
         result_q     <= bus.i_result;
         rd_num_q     <= bus.i_rd_num;
         align_err_q  <= align_err_q | align_bad;
      end
   end

   assign bus.o_control_wb = control_wb_q;
   assign bus.o_mem_data   = mem_data_q;
   assign bus.o_result     = result_q;
   assign bus.o_rd_num     = rd_num_q;
   assign bus.o_align_err  = align_err_q;

   // Load data is never forwarded from here; ID stalls on load-use instead.
   assign bus.o_ex_rd_data = bus.i_result;
   assign bus.o_ex_rd_num  = bus.i_rd_num;
   assign bus.o_ex_ctl_wr  = reg_write & ~mem_read;

`ifdef MA_DEBUG_PORT_EN
   logic [NB_DATA-1:0] dbg_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         dbg_q <= '0;
      end else if (bus.i_dbg_rd) begin
         dbg_q <= mem[bus.i_dbg_addr];
      end
   end

   assign bus.o_dbg_data = dbg_q;
`else
   // Without the debug port the memory is reachable only through the pipeline.
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: byte-level memory model plus literal expectations from the stage's rules.
module tb_memory_access;
   localparam int N_WORDS = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memory_access_if #(.N_WORDS(N_WORDS)) bus();
   memory_access #(.N_WORDS(N_WORDS)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   logic [7:0]  mb [4*N_WORDS];
   logic [1:0]  exp_cwb, nxt_cwb;
   logic [31:0] exp_md, nxt_md, exp_res, nxt_res;
   logic [4:0]  exp_rd, nxt_rd;
   logic        exp_err, nxt_err;
   logic        st_en;
   int          st_base, st_nb;
   logic [31:0] st_data;
   logic [31:0] cur_addr;
   logic [4:0]  cur_rdn;
   logic        cur_fwd_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_exp();
      exp_cwb = '0; exp_md = '0; exp_res = '0; exp_rd = '0; exp_err = 1'b0;
   endtask

   // Drive one access and work out what the stage must show after the next edge.
   task automatic apply(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic rw, input logic m2r, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rdn, input logic stall);
      int nb, base;
      logic mis;
      logic [31:0] v;
      bus.i_control_ma_wb = {rd, wr, sz, uns, rw, m2r};
      bus.i_result        = addr;
      bus.i_w_data_mem    = wdata;
      bus.i_rd_num        = rdn;
      bus.i_stall         = stall;
      cur_addr   = addr;
      cur_rdn    = rdn;
      cur_fwd_wr = rw & ~rd;
      nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      base = int'(addr % (4 * N_WORDS));
      mis  = (base % nb) != 0;
      v = 32'd0;
      if (rd && !mis) begin
         for (int i = 0; i < nb; i++) v |= 32'(mb[base + i]) << (8 * i);
         if (nb < 4 && !uns && v[8 * nb - 1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);
      end
      st_en = wr && !mis && !stall;
      st_base = base; st_nb = nb; st_data = wdata;
      if (stall) begin
         nxt_cwb = exp_cwb; nxt_md = exp_md; nxt_res = exp_res; nxt_rd = exp_rd; nxt_err = exp_err;
      end else begin
         nxt_cwb = {rw, m2r}; nxt_md = v; nxt_res = addr; nxt_rd = rdn;
         nxt_err = exp_err | ((rd | wr) & mis);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         clear_exp();
      end else begin
         if (st_en) for (int i = 0; i < st_nb; i++) mb[st_base + i] = st_data[8 * i +: 8];
         exp_cwb = nxt_cwb; exp_md = nxt_md; exp_res = nxt_res; exp_rd = nxt_rd; exp_err = nxt_err;
      end
      #2;
   endtask

   task automatic sw(input logic [31:0] addr, input logic [31:0] data, input logic stall);
      apply(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, addr, data, 5'd0, stall);
      tick();
   endtask

   task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
      apply(1'b1, 1'b0, sz, uns, 1'b1, 1'b1, addr, 32'h0, 5'd3, 1'b0);
      tick();
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
      apply(1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0, addr, data, 5'd0, 1'b0);
      tick();
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("control_wb", 32'(bus.o_control_wb), 32'(exp_cwb));
         chk("mem_data",   bus.o_mem_data, exp_md);
         chk("result",     bus.o_result, exp_res);
         chk("rd_num",     32'(bus.o_rd_num), 32'(exp_rd));
         chk("align_err",  32'(bus.o_align_err), 32'(exp_err));
         chk("ex_rd_data", bus.o_ex_rd_data, cur_addr);
         chk("ex_rd_num",  32'(bus.o_ex_rd_num), 32'(cur_rdn));
         chk("ex_ctl_wr",  32'(bus.o_ex_ctl_wr), 32'(cur_fwd_wr));
      end
   end

   initial begin
      rst = 1'b1;
      bus.i_control_ma_wb = '0; bus.i_result = '0; bus.i_w_data_mem = '0;
      bus.i_rd_num = '0; bus.i_stall = 1'b0;
`ifdef MA_DEBUG_PORT_EN
      bus.i_dbg_addr = '0; bus.i_dbg_rd = 1'b0;
`endif
      for (int i = 0; i < 4 * N_WORDS; i++) mb[i] = 8'h00;
      clear_exp();
      cur_addr = '0; cur_rdn = '0; cur_fwd_wr = 1'b0; st_en = 1'b0;
      st_base = 0; st_nb = 1; st_data = '0;
      nxt_cwb = '0; nxt_md = '0; nxt_res = '0; nxt_rd = '0; nxt_err = 1'b0;

      @(posedge clk); @(posedge clk); #2;
      chk("reset_control_wb", 32'(bus.o_control_wb), 32'h0);
      chk("reset_mem_data",   bus.o_mem_data, 32'h0);
      chk("reset_align_err",  32'(bus.o_align_err), 32'h0);
      rst = 1'b0;
      checking = 1'b1;

      sw(32'h10, 32'h89ABCDEF, 1'b0);
      ld(2'b11, 1'b0, 32'h10);
      chk("lw_10", bus.o_mem_data, 32'h89ABCDEF);
      chk("lw_control_wb", 32'(bus.o_control_wb), 32'h3);
      ld(2'b00, 1'b0, 32'h13);  chk("lb_13",  bus.o_mem_data, 32'hFFFFFF89);
      ld(2'b00, 1'b1, 32'h13);  chk("lbu_13", bus.o_mem_data, 32'h00000089);
      ld(2'b01, 1'b0, 32'h10);  chk("lh_10",  bus.o_mem_data, 32'hFFFFCDEF);
      ld(2'b01, 1'b1, 32'h12);  chk("lhu_12", bus.o_mem_data, 32'h000089AB);

      st(2'b00, 32'h11, 32'hFFFFFF55);
      ld(2'b11, 1'b0, 32'h10);  chk("sb_merge", bus.o_mem_data, 32'h89AB55EF);
      st(2'b01, 32'h12, 32'hABCD1234);
      ld(2'b11, 1'b0, 32'h10);  chk("sh_merge", bus.o_mem_data, 32'h123455EF);

      apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 5'd4, 1'b0);
      tick();
      chk("rw_prewrite", bus.o_mem_data, 32'h123455EF);
      ld(2'b11, 1'b0, 32'h10);  chk("rw_postwrite", bus.o_mem_data, 32'hCAFEF00D);

      sw(32'h20, 32'h11112222, 1'b0);
      chk("err_clean", 32'(bus.o_align_err), 32'h0);
      sw(32'h21, 32'hDEADBEEF, 1'b0);
      chk("err_set", 32'(bus.o_align_err), 32'h1);
      ld(2'b11, 1'b0, 32'h20);
      chk("mis_nowrite", bus.o_mem_data, 32'h11112222);
      chk("err_sticky", 32'(bus.o_align_err), 32'h1);
      ld(2'b01, 1'b0, 32'h21);  chk("mis_load_zero", bus.o_mem_data, 32'h0);

      sw(32'h04, 32'h5A5A0000, 1'b0);
      sw(32'h04, 32'hA5A5A5A5, 1'b1);
      chk("stall_hold_result", bus.o_result, 32'h04);
      ld(2'b11, 1'b0, 32'h04);  chk("stall_nowrite", bus.o_mem_data, 32'h5A5A0000);
      sw(32'h04, 32'hA5A5A5A5, 1'b0);
      ld(2'b11, 1'b0, 32'h04 + 4 * N_WORDS);
      chk("wrap_load", bus.o_mem_data, 32'hA5A5A5A5);

      apply(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h42, 32'h0, 5'd7, 1'b0);
      #1;
      chk("fwd_data", bus.o_ex_rd_data, 32'h42);
      chk("fwd_num",  32'(bus.o_ex_rd_num), 32'h7);
      chk("fwd_wr",   32'(bus.o_ex_ctl_wr), 32'h1);
      tick();
      chk("alu_control_wb", 32'(bus.o_control_wb), 32'h2);
      chk("alu_mem_data", bus.o_mem_data, 32'h0);
      apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd8, 1'b0);
      #1;
      chk("fwd_load_nowr", 32'(bus.o_ex_ctl_wr), 32'h0);
      tick();

      sw(32'h30, 32'h13579BDF, 1'b0);
      apply(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 32'h30, 32'h77777777, 5'd9, 1'b0);
      #1;
      rst = 1'b1;
      clear_exp();
      #1;
      chk("midrst_control_wb", 32'(bus.o_control_wb), 32'h0);
      chk("midrst_result",     bus.o_result, 32'h0);
      chk("midrst_rd_num",     32'(bus.o_rd_num), 32'h0);
      chk("midrst_mem_data",   bus.o_mem_data, 32'h0);
      chk("midrst_align_err",  32'(bus.o_align_err), 32'h0);
      tick();
      rst = 1'b0;
      ld(2'b11, 1'b0, 32'h30);
      chk("midrst_nowrite", bus.o_mem_data, 32'h13579BDF);

      @(posedge clk); #2;
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memory_access.md
# memory_access

Memory-access (MA) stage of the five-stage MIPS pipeline, directly downstream of `execution`. It consumes the EX/MA outputs (`o_control_ma_wb`, `o_result`, `o_w_data_mem`, `o_rd_num`), performs byte, halfword or word loads and stores into a private synchronous data memory, and registers the MA/WB pipeline outputs. It also drives the MA forwarding inputs of `execution` (`i_ma_rd_data`, `i_ma_rd_num`, `i_ma_ctl_wr`).

## Interface
Parameters:
- `NB_DATA`, 32, data and address width.
- `NB_CONTROL_MA`, 5, MA control field width.
- `NB_CONTROL_WB`, 2, WB control field width.
- `NB_ADDR_REGISTERS`, 5, register-number width.
- `N_WORDS`, 256, data memory depth in 32-bit words; must be a power of two.

Ports:
- `i_clk` in 1: clock; all state updates on its rising edge.
- `i_reset` in 1: reset; asynchronous and active-high.
- `i_control_ma_wb` in 7: bit layout `{mem_read, mem_write, size[1:0], unsigned, reg_write, mem_to_reg}`.
- `i_result` in 32: ALU result; it is the byte address for loads and stores.
- `i_w_data_mem` in 32: store data, right-aligned.
- `i_rd_num` in 5: destination register.
- `i_stall` in 1: halt from the debug unit; freezes the stage.
- `o_ex_rd_data` out 32: forwarded to EX; equals `i_result`.
- `o_ex_rd_num` out 5: forwarded to EX; equals `i_rd_num`.
- `o_ex_ctl_wr` out 1: forwarded to EX; equals `reg_write & ~mem_read`.
- `o_control_wb` out 2: registered `{reg_write, mem_to_reg}`.
- `o_mem_data` out 32: registered load data, already extended.
- `o_result` out 32: registered copy of `i_result`.
- `o_rd_num` out 5: registered copy of `i_rd_num`.
- `o_align_err` out 1: sticky flag for misaligned accesses.

## Operation
- **Word index:** `i_result[$clog2(N_WORDS)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `4*N_WORDS`. Lanes are little-endian: byte offset 0 is bits [7:0].
- **`size` encoding:**
  - 00 = byte.
  - 01 = halfword.
  - 11 = word.
  - 10 = reserved, treated as word.
- **Alignment:**
  - A halfword access needs `addr[0]` = 0.
  - A word access needs `addr[1:0]` = 0.
  - A misaligned access with `mem_read` or `mem_write` set sets `o_align_err`. Only reset clears it.
  - A misaligned store writes nothing.
  - A misaligned load returns 0.
- **Store (`mem_write` = 1):**
  - `sb`: writes `i_w_data_mem[7:0]` into lane `addr[1:0]`.
  - `sh`: writes `[15:0]` into the lane pair selected by `addr[1]`.
  - `sw`: writes the whole word.
  - Other lanes are left unchanged.
- **Load (`mem_read` = 1):**
  - The selected byte or halfword is right-aligned.
  - It is zero-extended when `unsigned` = 1, otherwise sign-extended.
  - When `mem_read` = 0, `o_mem_data` captures 0.
- **Both `mem_read` and `mem_write` set:** the store is performed and `o_mem_data` captures the pre-write word contents.
- **Forwarding outputs:** combinational pass-through of the current inputs. Load results are never forwarded from MA; the load-use stall in ID covers that case.
- **`i_stall` = 1:** no memory write occurs, all registered outputs hold, and `o_align_err` does not update.
- **Reset:**
  - `o_control_wb`, `o_mem_data`, `o_result`, `o_rd_num` and `o_align_err` clear to 0 immediately on assertion.
  - Memory contents are not cleared. They are initialised to 0 at simulation start.
- **Reset asserted mid-access:** the write on that edge is suppressed.

## Timing
- **Latency:** 1 cycle. Inputs present before edge *k* appear on the MA/WB outputs after edge *k*.
- **Memory writes:** committed at edge *k*. A load at the same word in cycle *k+1* returns the new data; there is no bypass hazard.
- **Memory reads:** synchronous, captured directly into `o_mem_data`. There is no extra output register.
- **Forwarding outputs:** zero latency (combinational).
- **Throughput:** one access per cycle when not stalled.

## Configuration
- **`MA_DEBUG_PORT_EN`:**
  - Defined: adds the inputs `i_dbg_addr` (word index, `$clog2(N_WORDS)` bits) and `i_dbg_rd` (1 bit), and the output `o_dbg_data` (32 bits).
  - When `i_dbg_rd` = 1, `o_dbg_data` registers `mem[i_dbg_addr]` on the next edge, regardless of `i_stall`. Otherwise it holds. Reset value is 0.
  - The debug read never disturbs pipeline accesses.
  - Undefined: these ports do not exist and memory is reachable only through the pipeline.

## Test plan
- **Word store/load:** `sw` 0x89ABCDEF to address 0x10, then `lw` from 0x10 with `reg_write` = 1 and `mem_to_reg` = 1 → the next cycle shows `o_mem_data` = 0x89ABCDEF and `o_control_wb` = 2'b11.
- **Byte/half extension:** after the word above, `lb` at 0x13 → 0xFFFFFF89; `lbu` at 0x13 → 0x00000089; `lh` at 0x10 → 0xFFFFCDEF; `lhu` at 0x12 → 0x000089AB.
- **Partial store:** `sb` 0x55 at 0x11 over 0x89ABCDEF → `lw` at 0x10 returns 0x89AB55EF. `sh` 0x1234 at 0x12 → `lw` returns 0x123455EF.
- **Misaligned:** `sw` at 0x21 → memory is unchanged, `o_align_err` = 1 and stays set across later aligned accesses until `i_reset`.
- **Stall and wrap:** `sw` 0xA5A5A5A5 to 0x04 with `i_stall` = 1 → `lw` at 0x04 returns the old value. The same store unstalled, then `lw` at 0x04 + 4·`N_WORDS` → 0xA5A5A5A5.
- **Forwarding and reset:** ALU op with `i_result` = 0x42, `i_rd_num` = 7, `reg_write` = 1 → `o_ex_rd_data` = 0x42, `o_ex_rd_num` = 7 and `o_ex_ctl_wr` = 1 in the same cycle. Asserting `i_reset` mid-cycle clears all registered outputs to 0 before the next edge.
